// File: rtl/mod_exp_engine_if.sv
// Operand/result handshake for the modular exponentiator.
// master drives the request; slave is the engine.
interface mod_exp_engine_if #(parameter int W = 16);
    logic         start;
    logic [W-1:0] base;
    logic [W-1:0] exp;
    logic [W-1:0] modulus;
    logic         busy;
    logic         done;
    logic         err;
    logic [W-1:0] result;

    modport master (output start, base, exp, modulus,
                    input  busy, done, err, result);
    modport slave  (input  start, base, exp, modulus,
                    output busy, done, err, result);
endinterface

// File: rtl/mod_exp_engine.sv
// Right-to-left square-and-multiply modular exponentiator.
// Each modular multiply consumes one multiplier bit per cycle, so no divider is needed.
//
// state  | meaning
// IDLE   | waiting for start
// CHECK  | screen modulus 0/1, init accumulator
// REDUCE | b = base mod n, restoring remainder, W cycles
// BIT    | inspect remaining exponent
// MUL    | acc = acc*b mod n, W cycles
// SQR    | b = b*b mod n, W cycles, then exp >>= 1
// FIN    | done pulse, result valid
module mod_exp_engine #(parameter int W = 16) (
    input  logic                 clk,
    input  logic                 rst_n,
    mod_exp_engine_if.slave      bus
);
    localparam int CW = $clog2(W);

    typedef enum logic [2:0] {
        S_IDLE, S_CHECK, S_REDUCE, S_BIT, S_MUL, S_SQR, S_FIN
    } state_t;

    state_t          state_q;
    logic [W-1:0]    base_q, exp_q, n_q, b_q, acc_q, result_q;
    logic [W+1:0]    t_q;
    logic [CW-1:0]   cnt_q;
    logic            busy_q, done_q, err_q;

    logic [W-1:0]    mm_x;
    logic [W+1:0]    n_ext, mm_s, mm_a, mm_t;
    logic [W:0]      rd_s, rd_t;

    // Interleaved multiply step: t stays below 3n before correction, so two
    // conditional subtractions always land it back in [0, n).
    always_comb begin
        mm_x  = (state_q == S_MUL) ? acc_q : b_q;
        n_ext = {2'b00, n_q};
        mm_s  = (t_q << 1) + (b_q[cnt_q] ? {2'b00, mm_x} : '0);
        mm_a  = (mm_s >= n_ext) ? mm_s - n_ext : mm_s;
        mm_t  = (mm_a >= n_ext) ? mm_a - n_ext : mm_a;
        rd_s  = {t_q[W-1:0], base_q[cnt_q]};
        rd_t  = (rd_s >= {1'b0, n_q}) ? rd_s - {1'b0, n_q} : rd_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            base_q   <= '0;
            exp_q    <= '0;
            n_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            result_q <= '0;
            t_q      <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        base_q  <= bus.base;
                        exp_q   <= bus.exp;
                        n_q     <= bus.modulus;
                        busy_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    t_q   <= '0;
                    cnt_q <= CW'(W - 1);
                    if (n_q == '0) begin
                        err_q    <= 1'b1;
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else if (n_q == W'(1)) begin
                        result_q <= '0;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else begin
                        acc_q   <= W'(1);
                        state_q <= S_REDUCE;
                    end
                end
                S_REDUCE: begin
                    t_q   <= {1'b0, rd_t};
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        b_q     <= rd_t[W-1:0];
                        state_q <= S_BIT;
                    end
                end
                S_BIT: begin
                    t_q   <= '0;
                    cnt_q <= CW'(W - 1);
                    if (exp_q == '0) begin
                        result_q <= acc_q;
                        done_q   <= 1'b1;
                        state_q  <= S_FIN;
                    end else if (exp_q[0]) begin
                        state_q <= S_MUL;
                    end else begin
                        state_q <= S_SQR;
                    end
                end
                S_MUL: begin
                    t_q   <= mm_t;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        acc_q <= mm_t[W-1:0];
                        t_q   <= '0;
                        cnt_q <= CW'(W - 1);
                        // Last exponent bit: the trailing square would be wasted work.
                        if ((exp_q >> 1) == '0) begin
                            exp_q   <= '0;
                            state_q <= S_BIT;
                        end else begin
                            state_q <= S_SQR;
                        end
                    end
                end
                S_SQR: begin
                    t_q   <= mm_t;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == '0) begin
                        b_q     <= mm_t[W-1:0];
                        exp_q   <= exp_q >> 1;
                        state_q <= S_BIT;
                    end
                end
                S_FIN: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;
    assign bus.result = result_q;
endmodule
